atm_session_ctrl: RTL and testbench

//  Session sequencer for the ATM FSM: card-in -> PIN -> menu -> transaction -> eject/retain.

---
 rtl/atm_session_pkg.sv | 22 ++
 rtl/stage_timeout_counter.sv | 38 +++
 rtl/atm_session_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_session_pkg.sv
// Package: atm_session_pkg
// Shared types for the ATM session controller: the session state encoding
// seen on state_o and a helper that identifies the in-session states.
package atm_session_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_PIN    = 3'd1,
    S_MENU   = 3'd2,
    S_TXN    = 3'd3,
    S_EJECT  = 3'd4,
    S_RETAIN = 3'd5
  } session_state_e;

  // A customer session is open while PIN entry, menu or transaction is running.
  function automatic logic is_session(input session_state_e s);
    return (s == S_PIN) || (s == S_MENU) || (s == S_TXN);
  endfunction

endpackage

// File: rtl/stage_timeout_counter.sv
// Module: stage_timeout_counter
// Single stage timer shared by all timed session stages.
// Ports:
//   clk, reset_n  clock and async active-low reset
//   clr           restart the count at 0 (wins over en)
//   en            count this cycle; the count holds when low
//   threshold     stage length in cycles
//   expire        combinational, high on the last cycle of the stage
module stage_timeout_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] threshold,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;

  // Count register: clear has priority, otherwise increment while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  // Expiry on count == threshold-1 so an idle stage lasts exactly threshold cycles.
  assign expire = en && (count_q == (threshold - CNT_W'(1)));

endmodule

// File: rtl/atm_session_ctrl.sv
// Module: atm_session_ctrl
// Session sequencer: card-in -> PIN -> menu -> transaction -> eject/retain.
// Owns one stage timer reloaded per stage, enforces the PIN retry limit and
// drives the card eject/retain strobes. All outputs are registered.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   card_in                          level, card present
//   key_activity, pin_valid, pin_ok  keypad events (pin_ok qualified by pin_valid)
//   txn_sel, txn_done, cancel        menu / bank / cancel pulses
//   state_o                          current session state
//   session_active                   high in PIN, MENU, TXN
//   tries_left                       PIN attempts remaining
//   timeout_evt                      pulse when a stage timer forced the exit
//   card_eject, card_retain          card reader strobes
// Optional build macro ATM_SESSION_AUDIT_EN adds saturating audit counters
// timeout_cnt[15:0] and retain_cnt[7:0].
module atm_session_ctrl
  import atm_session_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int PIN_TO        = 500,
  parameter int MENU_TO       = 800,
  parameter int TXN_TO        = 2000,
  parameter int TAKE_TO       = 1000,
  parameter int MAX_PIN_TRIES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               card_in,
  input  logic               key_activity,
  input  logic               pin_valid,
  input  logic               pin_ok,
  input  logic               txn_sel,
  input  logic               txn_done,
  input  logic               cancel,
  output logic [STATE_W-1:0] state_o,
  output logic               session_active,
  output logic [2:0]         tries_left,
  output logic               timeout_evt,
  output logic               card_eject,
  output logic               card_retain
`ifdef ATM_SESSION_AUDIT_EN
  ,
  output logic [15:0]        timeout_cnt,
  output logic [7:0]         retain_cnt
`endif
);

  session_state_e   state_q, state_d;
  logic [2:0]       tries_q, tries_d;
  logic             card_in_q;
  logic             session_active_q;
  logic             timeout_evt_q;
  logic             card_eject_q;
  logic             card_retain_q;
  logic             card_rise_s;
  logic             restart_s;
  logic             timeout_s;
  logic             timer_en_s;
  logic             timer_clr_s;
  logic             expire_s;
  logic [CNT_W-1:0] threshold_s;

  assign card_rise_s = card_in && !card_in_q;
  assign timer_en_s  = (state_q == S_PIN) || (state_q == S_MENU) ||
                       (state_q == S_TXN) || (state_q == S_EJECT);
  // Any state change restarts the stage timer, as do in-stage restarts.
  assign timer_clr_s = restart_s || (state_d != state_q);

  // Per-stage timeout threshold; untimed states never enable the counter.
  always_comb begin
    threshold_s = CNT_W'(PIN_TO);
    case (state_q)
      S_PIN:   threshold_s = CNT_W'(PIN_TO);
      S_MENU:  threshold_s = CNT_W'(MENU_TO);
      S_TXN:   threshold_s = CNT_W'(TXN_TO);
      S_EJECT: threshold_s = CNT_W'(TAKE_TO);
      default: threshold_s = CNT_W'(PIN_TO);
    endcase
  end

  stage_timeout_counter #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (timer_clr_s),
    .en        (timer_en_s),
    .threshold (threshold_s),
    .expire    (expire_s)
  );

  // Next-state, retry accounting and timeout attribution.
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    restart_s = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (card_rise_s) begin
          state_d = S_PIN;
          tries_d = 3'(MAX_PIN_TRIES);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PIN: begin
        // Card loss beats everything; then cancel > pin_valid > expiry > key.
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (cancel) begin
          state_d = S_EJECT;
        end else if (pin_valid) begin
          if (pin_ok) begin
            state_d = S_MENU;
          end else begin
            tries_d   = tries_q - 3'd1;
            restart_s = 1'b1;
            state_d   = (tries_q == 3'd1) ? S_RETAIN : S_PIN;
          end
        end else if (expire_s) begin
          state_d   = S_EJECT;
          timeout_s = 1'b1;
        end else if (key_activity) begin
          restart_s = 1'b1;
        end else begin
          state_d = S_PIN;
        end
      end
      S_MENU: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (cancel) begin
          state_d = S_EJECT;
        end else if (txn_sel) begin
          state_d = S_TXN;
        end else if (expire_s) begin
          state_d   = S_EJECT;
          timeout_s = 1'b1;
        end else if (key_activity) begin
          restart_s = 1'b1;
        end else begin
          state_d = S_MENU;
        end
      end
      S_TXN: begin
        // The bank owns this stage, so cancel is deliberately not looked at.
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (txn_done) begin
          state_d = S_MENU;
        end else if (expire_s) begin
          state_d   = S_EJECT;
          timeout_s = 1'b1;
        end else begin
          state_d = S_TXN;
        end
      end
      S_EJECT: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (expire_s) begin
          state_d   = S_RETAIN;
          timeout_s = 1'b1;
        end else begin
          state_d = S_EJECT;
        end
      end
      S_RETAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register plus registered outputs derived from the transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      tries_q          <= 3'(MAX_PIN_TRIES);
      card_in_q        <= 1'b0;
      session_active_q <= 1'b0;
      timeout_evt_q    <= 1'b0;
      card_eject_q     <= 1'b0;
      card_retain_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      tries_q          <= tries_d;
      card_in_q        <= card_in;
      session_active_q <= is_session(state_d);
      timeout_evt_q    <= timeout_s;
      card_eject_q     <= (state_d == S_EJECT) && (state_q != S_EJECT);
      card_retain_q    <= (state_d == S_RETAIN);
    end
  end

  assign state_o        = state_q;
  assign session_active = session_active_q;
  assign tries_left     = tries_q;
  assign timeout_evt    = timeout_evt_q;
  assign card_eject     = card_eject_q;
  assign card_retain    = card_retain_q;

`ifdef ATM_SESSION_AUDIT_EN
  logic [15:0] timeout_cnt_q;
  logic [7:0]  retain_cnt_q;

  // Saturating audit counters fed by the registered event strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt_q <= 16'd0;
      retain_cnt_q  <= 8'd0;
    end else begin
      if (timeout_evt_q && (timeout_cnt_q != 16'hFFFF)) begin
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
      end else begin
        timeout_cnt_q <= timeout_cnt_q;
      end
      if (card_retain_q && (retain_cnt_q != 8'hFF)) begin
        retain_cnt_q <= retain_cnt_q + 8'd1;
      end else begin
        retain_cnt_q <= retain_cnt_q;
      end
    end
  end

  assign timeout_cnt = timeout_cnt_q;
  assign retain_cnt  = retain_cnt_q;
`endif

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Testbench for atm_session_ctrl: directed session scenarios followed by
// randomized traffic, checked against a cycle-level reference model through
// an expectation queue drained by an independent monitor.
module tb_atm_session_ctrl;

  localparam int PIN_TO  = 8;
  localparam int MENU_TO = 10;
  localparam int TXN_TO  = 12;
  localparam int TAKE_TO = 6;
  localparam int MAX_T   = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic card_in = 1'b0, key_activity = 1'b0, pin_valid = 1'b0, pin_ok = 1'b0;
  logic txn_sel = 1'b0, txn_done = 1'b0, cancel = 1'b0;
  logic [2:0] state_o;
  logic session_active;
  logic [2:0] tries_left;
  logic timeout_evt, card_eject, card_retain;
`ifdef ATM_SESSION_AUDIT_EN
  logic [15:0] timeout_cnt;
  logic [7:0]  retain_cnt;
`endif

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .CNT_W(32), .PIN_TO(PIN_TO), .MENU_TO(MENU_TO), .TXN_TO(TXN_TO),
    .TAKE_TO(TAKE_TO), .MAX_PIN_TRIES(MAX_T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .card_in(card_in), .key_activity(key_activity),
    .pin_valid(pin_valid), .pin_ok(pin_ok), .txn_sel(txn_sel), .txn_done(txn_done),
    .cancel(cancel), .state_o(state_o), .session_active(session_active),
    .tries_left(tries_left), .timeout_evt(timeout_evt), .card_eject(card_eject),
    .card_retain(card_retain)
`ifdef ATM_SESSION_AUDIT_EN
    , .timeout_cnt(timeout_cnt), .retain_cnt(retain_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       act;
    logic [2:0] tries;
    logic       tmo;
    logic       ej;
    logic       ret;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stage entry time instead of a counter, plain ints for state.
  int m_st, m_tries, m_cycle, m_start, m_tmo_total, m_ret_total;
  bit m_card_prev;
  bit card_lvl;

  function automatic int stage_limit(input int s);
    case (s)
      1: return PIN_TO;
      2: return MENU_TO;
      3: return TXN_TO;
      4: return TAKE_TO;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_tries = MAX_T; m_card_prev = 1'b0;
    m_cycle = 0; m_start = 0; m_tmo_total = 0; m_ret_total = 0;
  endtask

  task automatic model_step(input bit c, input bit k, input bit pv, input bit pok,
                            input bit ts, input bit td, input bit cn);
    int nxt;
    bit tmo, restart, expired;
    exp_t e;
    nxt = m_st; tmo = 1'b0; restart = 1'b0;
    // The stage has run out when this cycle is its lim-th cycle.
    expired = (stage_limit(m_st) != 0) && ((m_cycle - m_start + 1) == stage_limit(m_st));
    case (m_st)
      0: if (c && !m_card_prev) begin nxt = 1; m_tries = MAX_T; end
      1: begin
        if (!c) nxt = 0;
        else if (cn) nxt = 4;
        else if (pv) begin
          if (pok) nxt = 2;
          else begin
            m_tries = m_tries - 1; restart = 1'b1;
            if (m_tries == 0) nxt = 5;
          end
        end
        else if (expired) begin nxt = 4; tmo = 1'b1; end
        else if (k) restart = 1'b1;
      end
      2: begin
        if (!c) nxt = 0;
        else if (cn) nxt = 4;
        else if (ts) nxt = 3;
        else if (expired) begin nxt = 4; tmo = 1'b1; end
        else if (k) restart = 1'b1;
      end
      3: begin
        if (!c) nxt = 0;
        else if (td) nxt = 2;
        else if (expired) begin nxt = 4; tmo = 1'b1; end
      end
      4: begin
        if (!c) nxt = 0;
        else if (expired) begin nxt = 5; tmo = 1'b1; end
      end
      default: nxt = 0;
    endcase
    if (nxt != m_st || restart) m_start = m_cycle + 1;
    e.st    = 3'(nxt);
    e.act   = (nxt >= 1) && (nxt <= 3);
    e.tries = 3'(m_tries);
    e.tmo   = tmo;
    e.ej    = (nxt == 4) && (m_st != 4);
    e.ret   = (nxt == 5);
    if (tmo && m_tmo_total < 65535) m_tmo_total++;
    if (e.ret && m_ret_total < 255) m_ret_total++;
    m_st = nxt; m_card_prev = c; m_cycle++;
    exp_q.push_back(e);
  endtask

  // One clock cycle of stimulus: drive at negedge, predict the next edge.
  task automatic cyc(input bit c, input bit k, input bit pv, input bit pok,
                     input bit ts, input bit td, input bit cn);
    @(negedge clk);
    card_lvl = c;
    card_in = c; key_activity = k; pin_valid = pv; pin_ok = pok;
    txn_sel = ts; txn_done = td; cancel = cn;
    model_step(c, k, pv, pok, ts, td, cn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(card_lvl, 0, 0, 0, 0, 0, 0);
  endtask

  // Wait until just after the edge that consumed the last driven cycle.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare each against the queue head.
  always @(posedge clk) begin
    #1;
    if (reset_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {state_o, session_active, tries_left, timeout_evt, card_eject, card_retain};
      n_tests++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got st=%0d act=%0d tries=%0d tmo=%0d ej=%0d ret=%0d expected st=%0d act=%0d tries=%0d tmo=%0d ej=%0d ret=%0d",
                 $time, mon_a.st, mon_a.act, mon_a.tries, mon_a.tmo, mon_a.ej, mon_a.ret,
                 mon_e.st, mon_e.act, mon_e.tries, mon_e.tmo, mon_e.ej, mon_e.ret);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    card_lvl = 1'b0;
    model_reset();
    #12;
    chk("reset_state", state_o, 0);
    chk("reset_tries", tries_left, MAX_T);
    chk("reset_pulses", {session_active, timeout_evt, card_eject, card_retain}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Happy path.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    settle();
    chk("happy_eject_state", state_o, 4);
    chk("happy_eject_pulse", card_eject, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // PIN timeout with no input: EJECT after exactly 8 PIN cycles.
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(7);
    settle();
    chk("pin_to_still_pin", state_o, 1);
    idle(1);
    settle();
    chk("pin_to_eject", state_o, 4);
    chk("pin_to_evt", timeout_evt, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // PIN timeout restarted by a key on PIN cycle 5.
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(4);
    cyc(1, 1, 0, 0, 0, 0, 0);
    idle(7);
    settle();
    chk("pin_key_still_pin", state_o, 1);
    idle(1);
    settle();
    chk("pin_key_eject", state_o, 4);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Three wrong PINs lead to RETAIN, held card does not restart.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    settle();
    chk("wrong1_tries", tries_left, 2);
    cyc(1, 0, 1, 0, 0, 0, 0);
    settle();
    chk("wrong2_tries", tries_left, 1);
    cyc(1, 0, 1, 0, 0, 0, 0);
    settle();
    chk("wrong3_retain_state", state_o, 5);
    chk("wrong3_retain_pulse", card_retain, 1);
    idle(1);
    settle();
    chk("retain_to_idle", state_o, 0);
    chk("retain_pulse_gone", card_retain, 0);
    idle(5);
    settle();
    chk("held_card_no_restart", state_o, 0);
`ifdef ATM_SESSION_AUDIT_EN
    chk("audit_timeout_cnt", timeout_cnt, 2);
    chk("audit_retain_cnt", retain_cnt, 1);
`endif
    cyc(0, 0, 0, 0, 0, 0, 0);

    // TXN timeout, cancel ignored, then EJECT not taken.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(10);
    settle();
    chk("txn_cancel_ignored", state_o, 3);
    idle(1);
    settle();
    chk("txn_to_eject", state_o, 4);
    chk("txn_to_evt", timeout_evt, 1);
    idle(5);
    settle();
    chk("eject_waiting", state_o, 4);
    idle(1);
    settle();
    chk("eject_to_retain", state_o, 5);
    idle(1);
    settle();
    chk("eject_retain_idle", state_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Card pulled in MENU.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("menu_pull_idle", state_o, 0);
    chk("menu_pull_no_pulse", {timeout_evt, card_eject, card_retain}, 0);

    // Asynchronous reset while in TXN.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_state", state_o, 0);
    chk("async_rst_tries", tries_left, MAX_T);
    chk("async_rst_active", session_active, 0);
    exp_q.delete();
    card_in = 1'b0; key_activity = 1'b0; pin_valid = 1'b0; pin_ok = 1'b0;
    txn_sel = 1'b0; txn_done = 1'b0; cancel = 1'b0;
    card_lvl = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) card_lvl = ~card_lvl;
      cyc(card_lvl,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 13) == 0,
          $urandom_range(0, 24) == 0);
    end
    idle(2);
    settle();
`ifdef ATM_SESSION_AUDIT_EN
    chk("audit_rand_timeout_cnt", timeout_cnt, m_tmo_total);
    chk("audit_rand_retain_cnt", retain_cnt, m_ret_total);
`endif
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
